// File: rtl/ieee754_addsub_seq.sv
// Multi-cycle IEEE754 single-precision add/subtract sequencer.
// Walks one operation through unpack, align, add/sub, iterative normalize and pack.
module ieee754_addsub_seq #(
    parameter logic [31:0] QNAN     = 32'h7FC0_0000,
    parameter logic [7:0]  EXP_BIAS = 8'd127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned FRAC_W = 32;
    localparam int unsigned SUM_W  = 33;
    localparam int unsigned EXP_W  = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADDSUB,
        S_NORM,
        S_PACK,
        S_OUT
    } state_e;

    state_e                    state_q, state_d;
    logic [WORD_W-1:0]         a_q, a_d;
    logic [WORD_W-1:0]         b_q, b_d;
    logic                      op_q, op_d;
    logic                      sign_q, sign_d;
    logic                      eff_sub_q, eff_sub_d;
    logic signed [EXP_W-1:0]   exp_q, exp_d;
    logic [FRAC_W-1:0]         frac_x_q, frac_x_d;
    logic [FRAC_W-1:0]         frac_y_q, frac_y_d;
    logic [7:0]                shamt_q, shamt_d;
    logic [SUM_W-1:0]          sum_q, sum_d;
    logic [WORD_W-1:0]         early_res_q, early_res_d;
    logic                      early_q, early_d;
    logic [WORD_W-1:0]         result_q, result_d;
    logic                      out_valid_q, out_valid_d;
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;

    // Operand decode used in UNPACK
    logic [7:0]              exp_a, exp_b;
    logic [FRAC_W-1:0]       frac_a, frac_b;
    logic                    sign_b_eff;
    logic                    swap;
    logic signed [EXP_W-1:0] exp_biased;

    assign exp_a      = a_q[30:23];
    assign exp_b      = b_q[30:23];
    assign frac_a     = (exp_a == 8'd0) ? '0 : {1'b1, a_q[22:0], 8'b0};
    assign frac_b     = (exp_b == 8'd0) ? '0 : {1'b1, b_q[22:0], 8'b0};
    assign sign_b_eff = b_q[31] ^ op_q;
    assign swap       = (exp_b > exp_a) || ((exp_b == exp_a) && (frac_b > frac_a));
    // Exponent is carried unbiased internally and rebiased for packing
    assign exp_biased = exp_q + $signed(EXP_W'(EXP_BIAS));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        sign_d      = sign_q;
        eff_sub_d   = eff_sub_q;
        exp_d       = exp_q;
        frac_x_d    = frac_x_q;
        frac_y_d    = frac_y_q;
        shamt_d     = shamt_q;
        sum_d       = sum_q;
        early_res_d = early_res_q;
        early_d     = early_q;
        result_d    = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    early_d = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if ((exp_a == 8'hFF) || (exp_b == 8'hFF)) begin
                    early_res_d = QNAN;
                    early_d     = 1'b1;
                    state_d     = S_PACK;
                end else begin
                    eff_sub_d = a_q[31] ^ sign_b_eff;
                    if (swap) begin
                        sign_d   = sign_b_eff;
                        exp_d    = EXP_W'({2'b00, exp_b}) - EXP_W'({2'b00, EXP_BIAS});
                        frac_x_d = frac_b;
                        frac_y_d = frac_a;
                        shamt_d  = exp_b - exp_a;
                    end else begin
                        sign_d   = a_q[31];
                        exp_d    = EXP_W'({2'b00, exp_a}) - EXP_W'({2'b00, EXP_BIAS});
                        frac_x_d = frac_a;
                        frac_y_d = frac_b;
                        shamt_d  = exp_a - exp_b;
                    end
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                frac_y_d = (shamt_q >= 8'd32) ? '0 : (frac_y_q >> shamt_q[4:0]);
                state_d  = S_ADDSUB;
            end
            S_ADDSUB: begin
                if (eff_sub_q) begin
                    sum_d = {1'b0, frac_x_q} - {1'b0, frac_y_q};
                end else begin
                    sum_d = {1'b0, frac_x_q} + {1'b0, frac_y_q};
                end
                if (sum_d == '0) begin
                    early_res_d = '0;
                    early_d     = 1'b1;
                    state_d     = S_PACK;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // One normalization step per cycle
                if (sum_q[32]) begin
                    sum_d   = sum_q >> 1;
                    exp_d   = exp_q + 10'sd1;
                    state_d = S_PACK;
                end else if (sum_q[31]) begin
                    state_d = S_PACK;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 10'sd1;
                end
            end
            S_PACK: begin
                if (early_q) begin
                    result_d = early_res_q;
                end else if (exp_biased >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'b0};
                end else if (exp_biased <= 10'sd0) begin
                    result_d = {sign_q, 31'b0};
                end else begin
                    result_d = {sign_q, exp_biased[7:0], sum_q[30:8]};
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_valid_d = (state_d == S_OUT);
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            exp_q       <= '0;
            frac_x_q    <= '0;
            frac_y_q    <= '0;
            shamt_q     <= '0;
            sum_q       <= '0;
            early_res_q <= '0;
            early_q     <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            exp_q       <= exp_d;
            frac_x_q    <= frac_x_d;
            frac_y_q    <= frac_y_d;
            shamt_q     <= shamt_d;
            sum_q       <= sum_d;
            early_res_q <= early_res_d;
            early_q     <= early_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ieee754_addsub_seq.sv
// Scoreboard bench for ieee754_addsub_seq: result words, latency and handshake behaviour.
module tb_ieee754_addsub_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] sb_res[$];
    int          sb_lat[$];

    ieee754_addsub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for it, then take it after `hold` stalled cycles
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_op, input logic top,
                          input logic [31:0] eres, input int elat, input int hold);
        int          lat;
        bit          got;
        logic [31:0] r;
        int          l;
        @(negedge clk);
        a         = ta;
        b         = tb_op;
        op        = top;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        sb_res.push_back(eres);
        sb_lat.push_back(elat);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_after_accept", 64'({busy, in_ready, out_valid}), 64'b100);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        r = 32'hDEAD_BEEF;
        l = -1;
        if (sb_res.size() > 0) begin
            r = sb_res.pop_front();
            l = sb_lat.pop_front();
        end
        check("result", 64'(result), 64'(r));
        check("latency", 64'(lat), 64'(l));
        check("out_state", 64'({in_ready, busy}), 64'b01);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_stable", 64'({out_valid, in_ready, busy, result}), 64'({1'b1, 1'b0, 1'b1, r}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_take", 64'({out_valid, busy, in_ready}), 64'b001);
        out_ready = 1'b0;
    endtask

    initial begin
        bit seen_out;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'({out_valid, busy, in_ready, result}), 64'({1'b0, 1'b0, 1'b1, 32'h0}));
        rst = 1'b0;

        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 5, 0);  // 1+1 carry
        run_op(32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 6, 0);  // 1.5-1
        run_op(32'h4000_0000, 32'hC000_0000, 1'b0, 32'h0000_0000, 4, 0);  // exact cancel
        run_op(32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 2, 0);  // inf operand
        run_op(32'h3F80_0000, 32'hFF80_0000, 1'b1, 32'h7FC0_0000, 2, 0);  // inf on B
        run_op(32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, 5, 0);  // d=30 truncation
        run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 5, 0);  // overflow
        run_op(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 6, 0);  // 1-2 swaps sign
        run_op(32'h0000_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 5, 0);  // zero operand
        run_op(32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 32'h3380_0000, 29, 0); // L=24 normalize
        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 5, 10); // stalled consumer
        run_op(32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 6, 0);  // accepted after stall

        // Abort an operation with reset during its NORM phase
        @(negedge clk);
        a         = 32'h3FC0_0000;
        b         = 32'h3F80_0000;
        op        = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sb_res.push_back(32'h3F00_0000);
        sb_lat.push_back(6);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_abort", 64'({out_valid, busy, in_ready, result}), 64'({1'b0, 1'b0, 1'b1, 32'h0}));
        void'(sb_res.pop_back());
        void'(sb_lat.pop_back());
        seen_out = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_out = 1'b1;
        end
        check("no_aborted_output", 64'(seen_out), 64'd0);
        out_ready = 1'b0;

        run_op(32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 6, 0);  // after abort
        check("scoreboard_empty", 64'(sb_res.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
